// File: rtl/kfirkb_pkg.sv
// Shared definitions for the IR keyboard link: frame geometry, decoder states
// and the sampling points derived from the bit period.
package kfirkb_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    // Takes "period minus one" so the parameter can be passed straight through.
    function automatic logic [16:0] bit_period(input logic [15:0] last);
        return {1'b0, last} + 17'd1;
    endfunction

    function automatic logic [15:0] quarter_phase(input logic [15:0] last);
        return 16'(bit_period(last) >> 2);
    endfunction

    function automatic logic [15:0] half_phase(input logic [15:0] last);
        return 16'(bit_period(last) >> 1);
    endfunction

    function automatic logic [15:0] three_quarter_phase(input logic [15:0] last);
        return half_phase(last) + quarter_phase(last);
    endfunction

endpackage

// File: rtl/kfirkb_ir_sync.sv
// Synchronizer chain for the raw IR pin with rise/fall detection on the
// synchronized level.
module kfirkb_ir_sync #(
    parameter int sync_stages = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic ir_i,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic [sync_stages-1:0] chain_q;
    logic [sync_stages:0]   arm_q;
    logic                   prev_q;

    // Edges stay masked until the chain and prev_q hold real pin samples, so a
    // line that is already low when reset releases does not look like a start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '1;
            arm_q   <= '0;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[sync_stages-2:0], ir_i};
            arm_q   <= {arm_q[sync_stages-1:0], 1'b1};
            prev_q  <= chain_q[sync_stages-1];
        end
    end

    assign level_o = chain_q[sync_stages-1];
    assign fall_o  = arm_q[sync_stages] & prev_q & ~level_o;
    assign rise_o  = arm_q[sync_stages] & ~prev_q & level_o;

endmodule

// File: rtl/kfirkb_ir_decoder.sv
// Manchester IR frame receiver: recovers 8-bit keycodes and presents them with
// the irq / clear_keycode handshake of the PS/2 keyboard core.
module kfirkb_ir_decoder
    import kfirkb_pkg::*;
#(
    parameter logic [15:0] bit_phase_cycle = 16'd22000 - 16'd1,
    parameter int          sync_stages     = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ir_signal,
    input  logic       clear_keycode,
    output logic       irq,
    output logic [7:0] keycode,
    output logic       frame_error,
    output logic       overrun
);

    localparam logic [15:0] PHASE_Q  = quarter_phase(bit_phase_cycle);
    localparam logic [15:0] PHASE_H  = half_phase(bit_phase_cycle);
    localparam logic [15:0] PHASE_T3 = three_quarter_phase(bit_phase_cycle);

    logic lineLevel;
    logic lineFall;
    logic lineRise;

    kfirkb_ir_sync #(
        .sync_stages(sync_stages)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .ir_i    (ir_signal),
        .level_o (lineLevel),
        .fall_o  (lineFall),
        .rise_o  (lineRise)
    );

    state_e                 state_q, state_d;
    logic [15:0]            phase_q, phase_d;
    logic [3:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   a_q, a_d;
    logic [DATA_BITS-1:0]   key_q, key_d;
    logic                   irq_q, irq_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   deliver;
    logic                   inWindow;
    logic [2:0]             dataIdx;

    assign inWindow = (phase_q > PHASE_Q) && (phase_q < PHASE_T3);
    assign dataIdx  = 3'(bit_q - 4'd1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            a_q     <= 1'b0;
            key_q   <= '0;
            irq_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            a_q     <= a_d;
            key_q   <= key_d;
            irq_q   <= irq_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        a_d     = a_q;
        key_d   = key_q;
        irq_d   = irq_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        if (state_q == IDLE) begin
            if (lineFall) begin
                state_d = START;
                phase_d = '0;
                bit_d   = '0;
            end
        end else begin
            phase_d = (phase_q == bit_phase_cycle) ? '0 : phase_q + 16'd1;
            // The mid-bit transition re-anchors the phase, absorbing clock mismatch.
            if ((lineFall || lineRise) && inWindow) begin
                phase_d = PHASE_H;
            end
            if (phase_q == PHASE_Q) begin
                a_d = lineLevel;
            end

            unique case (state_q)
                START: begin
                    if (phase_q == PHASE_Q && lineLevel) begin
                        state_d = IDLE;
                        phase_d = '0;
                    end else if (phase_q == PHASE_T3 && (!lineLevel || a_q == lineLevel)) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                        phase_d = '0;
                    end else if (phase_q == bit_phase_cycle) begin
                        state_d = DATA;
                        bit_d   = bit_q + 4'd1;
                    end
                end
                DATA: begin
                    if (phase_q == PHASE_T3) begin
                        if (a_q == lineLevel) begin
                            ferr_d  = 1'b1;
                            state_d = IDLE;
                            phase_d = '0;
                        end else begin
                            shift_d[dataIdx] = lineLevel;
                        end
                    end else if (phase_q == bit_phase_cycle) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'(FRAME_BITS - 2)) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (phase_q == PHASE_T3) begin
                        state_d = IDLE;
                        phase_d = '0;
                        if (a_q || !lineLevel) begin
                            ferr_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end

        // An acknowledge in the delivery cycle frees the slot for the new frame.
        if (deliver) begin
            if (!irq_q || clear_keycode) begin
                key_d = shift_q;
                irq_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (clear_keycode) begin
            irq_d = 1'b0;
        end
    end

    assign irq         = irq_q;
    assign keycode     = key_q;
    assign frame_error = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_kfirkb_ir_decoder.sv
// Bench for kfirkb_ir_decoder: a Manchester transmitter model drives the pin and
// a handshake model predicts keycode, irq, overrun and frame_error activity.
module tb_kfirkb_ir_decoder;

    localparam logic [15:0] BPC = 16'd39;
    localparam int P  = 40;
    localparam int SS = 2;
    localparam int T3 = (P / 2) + (P / 4);

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ir_signal = 1'b1;
    logic       clear_keycode = 1'b0;
    logic       irq;
    logic [7:0] keycode;
    logic       frame_error;
    logic       overrun;

    kfirkb_ir_decoder #(
        .bit_phase_cycle(BPC),
        .sync_stages    (SS)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ir_signal     (ir_signal),
        .clear_keycode (clear_keycode),
        .irq           (irq),
        .keycode       (keycode),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   feCnt = 0;
    int   ovrCnt = 0;
    int   irqRiseCyc = -1;
    logic irqPrev = 1'b0;
    int   startCyc = 0;

    logic       modelIrq = 1'b0;
    logic [7:0] modelKey = 8'h00;
    int         expFe = 0;
    int         expOvr = 0;

    // Output activity is observed on the falling edge, away from the DUT's updates.
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (frame_error) feCnt++;
        if (overrun) ovrCnt++;
        if (irq && !irqPrev) irqRiseCyc = cyc;
        irqPrev = irq;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic emitBit(input logic b, input int period);
        ir_signal = b ? 1'b0 : 1'b1;
        waitClocks(period / 2);
        ir_signal = b ? 1'b1 : 1'b0;
        waitClocks(period - period / 2);
    endtask

    // Sends one frame; a non-negative badBit holds that data bit low for a whole
    // period and abandons the rest of the frame.
    task automatic applyStimulus(input logic [7:0] code, input int period, input int badBit);
        logic aborted;
        aborted = 1'b0;
        startCyc = cyc;
        emitBit(1'b1, period);
        for (int i = 0; i < 8; i++) begin
            if (!aborted) begin
                if (i == badBit) begin
                    ir_signal = 1'b0;
                    waitClocks(period);
                    aborted = 1'b1;
                end else begin
                    emitBit(code[i], period);
                end
            end
        end
        if (!aborted) emitBit(1'b1, period);
        ir_signal = 1'b1;
        waitClocks(2 * period);
    endtask

    task automatic modelFrame(input logic [7:0] code);
        if (!modelIrq) begin
            modelKey = code;
            modelIrq = 1'b1;
        end else begin
            expOvr++;
        end
    endtask

    task automatic hostClear();
        clear_keycode = 1'b1;
        waitClocks(1);
        clear_keycode = 1'b0;
        modelIrq = 1'b0;
        waitClocks(2);
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, " irq"}, 32'(irq), 32'(modelIrq));
        checkOutput({tag, " keycode"}, 32'(keycode), 32'(modelKey));
        checkOutput({tag, " frame_error count"}, 32'(feCnt), 32'(expFe));
        checkOutput({tag, " overrun count"}, 32'(ovrCnt), 32'(expOvr));
    endtask

    initial begin
        int lat;
        logic [7:0] code;
        int per;

        waitClocks(5);
        checkOutput("reset irq", 32'(irq), 32'(0));
        checkOutput("reset keycode", 32'(keycode), 32'(0));
        checkOutput("reset frame_error", 32'(frame_error), 32'(0));
        checkOutput("reset overrun", 32'(overrun), 32'(0));
        reset_n = 1'b1;
        waitClocks(P);

        $display("[TB] single frame 1C");
        applyStimulus(8'h1C, P, -1);
        modelFrame(8'h1C);
        checkState("single");
        // The pin changes half a clock ahead of the first sampling edge, adding one count.
        lat = irqRiseCyc - startCyc;
        checkOutput("latency in window", 32'((lat >= SS + 9 * P + T3 + 1) && (lat <= SS + 9 * P + T3 + 3)), 32'(1));
        hostClear();
        checkOutput("clear irq", 32'(irq), 32'(0));
        checkOutput("clear keeps keycode", 32'(keycode), 32'h1C);

        $display("[TB] back-to-back F0, 1C");
        applyStimulus(8'hF0, P, -1);
        modelFrame(8'hF0);
        checkState("b2b first");
        hostClear();
        applyStimulus(8'h1C, P, -1);
        modelFrame(8'h1C);
        checkState("b2b second");

        $display("[TB] overrun with 32");
        applyStimulus(8'h32, P, -1);
        modelFrame(8'h32);
        checkState("overrun");
        hostClear();

        $display("[TB] data bit 3 without transition");
        applyStimulus(8'h1C, P, 3);
        expFe++;
        checkState("violation");
        applyStimulus(8'h55, P, -1);
        modelFrame(8'h55);
        checkState("after violation");
        hostClear();

        $display("[TB] idle glitch");
        ir_signal = 1'b0;
        waitClocks(5);
        ir_signal = 1'b1;
        waitClocks(3 * P);
        checkState("glitch");

        $display("[TB] bit period tolerance");
        applyStimulus(8'hAA, 38, -1);
        modelFrame(8'hAA);
        checkState("period 38");
        hostClear();
        applyStimulus(8'hAA, 42, -1);
        modelFrame(8'hAA);
        checkState("period 42");

        $display("[TB] random frames");
        for (int i = 0; i < 8; i++) begin
            code = 8'($urandom);
            per = 38 + int'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) hostClear();
            applyStimulus(code, per, -1);
            modelFrame(code);
            checkState("random");
        end

        $display("[TB] reset mid-frame");
        hostClear();
        applyStimulus(8'h3A, P, -1);
        modelFrame(8'h3A);
        checkState("pre-reset");
        emitBit(1'b1, P);
        emitBit(1'b1, P);
        emitBit(1'b0, P);
        ir_signal = 1'b0;
        reset_n = 1'b0;
        waitClocks(3);
        modelIrq = 1'b0;
        modelKey = 8'h00;
        checkOutput("mid reset irq", 32'(irq), 32'(0));
        checkOutput("mid reset keycode", 32'(keycode), 32'(0));
        checkOutput("mid reset frame_error", 32'(frame_error), 32'(0));
        checkOutput("mid reset overrun", 32'(overrun), 32'(0));
        reset_n = 1'b1;
        waitClocks(3 * P);
        checkState("low line after reset");
        ir_signal = 1'b1;
        waitClocks(2 * P);
        applyStimulus(8'h96, P, -1);
        modelFrame(8'h96);
        checkState("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
